hazard_ctrl: RTL

HAZARD_CTRL -- requirements
Module: hazard_ctrl

---
 rtl/hazard_ctrl.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/hazard_ctrl.sv
// Pipeline hazard control: load-use/RAW stalls, branch flush, halt drain, EX forwarding.
// Define HAZARD_FORWARDING_EN for EX forwarding; default build stalls on EX/MEM RAW instead.
module hazard_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  rsID,
  input  logic [4:0]  rtID,
  input  logic        useRsID,
  input  logic        useRtID,
  input  logic        branchTakenID,
  input  logic        haltID,
  input  logic [4:0]  rsEX,
  input  logic [4:0]  rtEX,
  input  logic        regWriteEX,
  input  logic        memReadEX,
  input  logic [4:0]  writeRegEX,
  input  logic        regWriteMEM,
  input  logic [4:0]  writeRegMEM,
  input  logic        regWriteWB,
  input  logic [4:0]  writeRegWB,
  output logic        pcWrite,
  output logic        ifIdWrite,
  output logic        ifIdFlush,
  output logic        idExBubble,
  output logic [1:0]  fwdA,
  output logic [1:0]  fwdB,
  output logic [1:0]  state,
  output logic [15:0] stallCnt,
  output logic [15:0] flushCnt
);

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    STALL  = 2'd1,
    DRAIN  = 2'd2,
    HALTED = 2'd3
  } st_e;

  st_e         state_q;
  logic [1:0]  drain_q;
  logic [15:0] stall_cnt_q, stall_cnt_d;
  logic [15:0] flush_cnt_q, flush_cnt_d;

  function automatic logic hit(
    input logic       we,
    input logic [4:0] wr,
    input logic [4:0] r
  );
    return we && (wr == r) && (r != 5'd0);
  endfunction

  logic       active;
  logic       ex_hit_id;
  logic       raw_stall;
  logic       stall;
  logic       halt_go;
  logic       flush;
  logic [1:0] fwd_a_raw;
  logic [1:0] fwd_b_raw;

  assign active = (state_q == RUN) || (state_q == STALL);

  assign ex_hit_id =
    (useRsID && hit(regWriteEX, writeRegEX, rsID)) ||
    (useRtID && hit(regWriteEX, writeRegEX, rtID));

`ifdef HAZARD_FORWARDING_EN
  assign raw_stall = memReadEX && ex_hit_id;

  assign fwd_a_raw =
    hit(regWriteMEM, writeRegMEM, rsEX) ? 2'b10 :
    hit(regWriteWB,  writeRegWB,  rsEX) ? 2'b01 :
                                          2'b00;
  assign fwd_b_raw =
    hit(regWriteMEM, writeRegMEM, rtEX) ? 2'b10 :
    hit(regWriteWB,  writeRegWB,  rtEX) ? 2'b01 :
                                          2'b00;
`else
  logic mem_hit_id;
  logic unused_fwd_in;

  // WB needs no stall: the register file writes before it is read
  assign mem_hit_id =
    (useRsID && hit(regWriteMEM, writeRegMEM, rsID)) ||
    (useRtID && hit(regWriteMEM, writeRegMEM, rtID));

  assign raw_stall = ex_hit_id || mem_hit_id;
  assign fwd_a_raw = 2'b00;
  assign fwd_b_raw = 2'b00;

  assign unused_fwd_in =
    ^{rsEX, rtEX, regWriteWB, writeRegWB, memReadEX};
`endif

  assign stall   = active && raw_stall;
  assign halt_go = active && haltID && !stall;
  assign flush   = active && branchTakenID && !stall && !haltID;

  always_comb begin
    pcWrite    = 1'b1;
    ifIdWrite  = 1'b1;
    ifIdFlush  = 1'b0;
    idExBubble = 1'b0;
    fwdA       = fwd_a_raw;
    fwdB       = fwd_b_raw;
    unique case (1'b1)
      !rst: begin
        pcWrite    = 1'b0;
        ifIdWrite  = 1'b0;
        ifIdFlush  = 1'b1;
        idExBubble = 1'b1;
        fwdA       = 2'b00;
        fwdB       = 2'b00;
      end
      rst && (state_q == HALTED): begin
        pcWrite    = 1'b0;
        ifIdWrite  = 1'b0;
        idExBubble = 1'b1;
        fwdA       = 2'b00;
        fwdB       = 2'b00;
      end
      rst && (state_q == DRAIN): begin
        pcWrite    = 1'b0;
        ifIdWrite  = 1'b0;
        idExBubble = 1'b1;
      end
      rst && stall: begin
        pcWrite    = 1'b0;
        ifIdWrite  = 1'b0;
        idExBubble = 1'b1;
      end
      default: begin
        ifIdFlush  = flush;
      end
    endcase
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (stall && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end
    if (flush && (flush_cnt_q != 16'hFFFF)) begin
      flush_cnt_d = flush_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= RUN;
      drain_q     <= 2'd0;
      stall_cnt_q <= 16'd0;
      flush_cnt_q <= 16'd0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
      unique case (state_q)
        RUN, STALL: begin
          if (halt_go) begin
            state_q <= DRAIN;
            drain_q <= 2'd0;
          end else if (stall) begin
            state_q <= STALL;
          end else begin
            state_q <= RUN;
          end
        end
        DRAIN: begin
          if (drain_q == 2'd2) begin
            state_q <= HALTED;
          end else begin
            drain_q <= drain_q + 2'd1;
          end
        end
        HALTED: begin
          state_q <= HALTED;
        end
        default: begin
          state_q <= RUN;
        end
      endcase
    end
  end

  assign state    = state_q;
  assign stallCnt = stall_cnt_q;
  assign flushCnt = flush_cnt_q;

endmodule
